fir_controller: RTL
===================

# fir_controller

Control FSM for the FIR filter, directly upstream of the processed-sample counter. It sequences the datapath register file and ALU through coefficient loading and a 4-tap multiply-accumulate per sample. It pulses `cnt_up` and `clear` to the sample counter and consumes its `one_k_samples` flag, producing a one-cycle `batch_done` event. It also reports busy status (`modwait`) and error status (`err`) to the bus-side wrapper.

## Interface
Parameters: none; all widths and encodings are fixed.

- `clk` in 1: system clock, rising-edge active.
- `n_rst` in 1: asynchronous active-low reset.
- `dr` in 1: data ready; a new sample is held on the datapath load input.
- `lc` in 1: load coefficient; a coefficient is held on the datapath load input.
- `overflow` in 1: ALU overflow, combinational from the datapath for the current op.
- `one_k_samples` in 1: rollover flag from the sample counter.
- `cnt_up` out 1: increment request to the sample counter.
- `clear` out 1: synchronous clear to the sample counter.
- `modwait` out 1: controller busy.
- `err` out 1: error state indicator.
- `batch_done` out 1: one-cycle pulse when 1000 samples are complete.
- `op` out 3: ALU op. Encodings: NOP=0, COPY=1, LOAD1 (sample)=2, LOAD2 (coefficient)=3, ADD=4, SUB=5, MUL=6.
- `src1`, `src2`, `dest` out 4 each: register-file indices.

## Operation
- States: IDLE, STORE, ZERO, SORT1–SORT4, MUL1, ADD1, MUL2, SUB1, MUL3, ADD2, MUL4, SUB2, LC0, WAIT1, LC1, WAIT2, LC2, WAIT3, LC3, EIDLE.
- Outputs are decoded from the current state (Moore), except `cnt_up`. Unlisted fields are 0 and unlisted ops are NOP.
- **IDLE**:
  - `dr`=1 → STORE.
  - else `lc`=1 → LC0 (`dr` has priority).
  - else stay in IDLE.
- **Sample sequence:**
  - STORE: LOAD1, dest=5. If `dr`=0 in STORE → EIDLE; else → ZERO.
  - ZERO: SUB r0=r0-r0.
  - SORT1: COPY r1←r2. SORT2: COPY r2←r3. SORT3: COPY r3←r4. SORT4: COPY r4←r5.
  - MUL1: r10=r1*r6. ADD1: r0=r0+r10.
  - MUL2: r10=r2*r7. SUB1: r0=r0-r10.
  - MUL3: r10=r3*r8. ADD2: r0=r0+r10.
  - MUL4: r10=r4*r9. SUB2: r0=r0-r10.
  - After SUB2 → IDLE.
- **Overflow:** in any of ADD1, SUB1, ADD2, SUB2, `overflow`=1 → EIDLE instead of the next state. The op is still driven that cycle.
- **`cnt_up`** = (state==SUB2) && !`overflow`. It is combinational and asserts exactly once per successfully processed sample.
- **Coefficient sequence:**
  - LC0: LOAD2, dest=6, `clear`=1.
  - WAIT1, WAIT2, WAIT3: wait until `lc`=1, then go to LC1, LC2, LC3 respectively.
  - LC1: dest=7. LC2: dest=8. LC3: dest=9, then → IDLE.
  - `dr` is ignored in WAIT states.
- **EIDLE:** `err`=1, `modwait`=0.
  - `dr`=1 → STORE.
  - else `lc`=1 → LC0.
  - else stay in EIDLE.
  - `err` drops on the transition out.
- **`modwait`**:
  - 1 in every state except IDLE, EIDLE, WAIT1–WAIT3.
  - It is registered from next-state, so it rises in the same cycle the FSM enters STORE or LC0.
- **`batch_done`**: a register holds the previous value of `one_k_samples`. `batch_done` = `one_k_samples` && !prev, registered, giving exactly one pulse per rising edge of the flag.

## Timing
- **Reset** (asynchronous, `n_rst`=0):
  - state=IDLE.
  - `modwait`=0, `err`=0, `batch_done`=0, `cnt_up`=0, `clear`=0.
  - `op`=NOP; `src1`, `src2`, `dest`=0.
  - prev `one_k_samples` register cleared.
  - Reset mid-sequence aborts with no `cnt_up`.
- **Sample latency:** `dr` sampled high in IDLE at edge k.
  - STORE occupies cycle k+1 and SUB2 occupies cycle k+14 (14 busy cycles).
  - IDLE is re-entered at cycle k+15.
- **Coefficient load:** each LCn is one cycle; `clear` is high only during the LC0 cycle.
- **`batch_done`:** rises one cycle after `one_k_samples` rises and lasts exactly one cycle. A flag held high produces no repeat pulse.
- **Simultaneous inputs:** `dr` and `lc` both high in IDLE or EIDLE → STORE.

## Test plan
- **Reset mid-sequence:** `n_rst` low during MUL2 → all outputs 0, state IDLE; no `cnt_up` pulse.
- **Coefficient load:** 4 `lc` pulses separated by idle gaps → LOAD2 with dest=6,7,8,9 in order; `clear` pulses once, in LC0; `modwait` is 0 during WAIT states.
- **Normal sample:** `dr`=1 for 2 cycles with `overflow`=0 → op sequence 2,5,1,1,1,1,6,4,6,5,6,4,6,5 with dest=5,0,1,2,3,4,10,0,10,0,10,0,10,0; one `cnt_up` pulse at cycle k+14; `modwait` high for exactly 14 cycles.
- **Overflow:** `overflow`=1 in SUB1 → next state EIDLE, `err`=1, `modwait`=0, no `cnt_up`. A subsequent `dr`=1 → STORE and `err`=0.
- **Dropped `dr`:** `dr` high for only 1 cycle (low in STORE) → EIDLE with `err`=1.
- **Batch:** 1000 samples with a counter model; `one_k_samples` held high for 20 cycles → exactly one `batch_done` pulse, one cycle after the flag rises.

Source files
------------

// File: rtl/fir_controller.sv
// Control FSM for the 4-tap FIR datapath: coefficient loading, per-sample
// multiply-accumulate sequencing, sample-counter handshake and batch event.
module fir_controller (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dr,
  input  logic       lc,
  input  logic       overflow,
  input  logic       one_k_samples,
  output logic       cnt_up,
  output logic       clear,
  output logic       modwait,
  output logic       err,
  output logic       batch_done,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned REG_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_COPY  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD1 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOAD2 = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);

  typedef enum logic [4:0] {
    IDLE, STORE, ZERO, SORT1, SORT2, SORT3, SORT4,
    MUL1, ADD1, MUL2, SUB1, MUL3, ADD2, MUL4, SUB2,
    LC0, WAIT1, LC1, WAIT2, LC2, WAIT3, LC3, EIDLE
  } state_t;

  state_t state, nxt_state;

  logic [OP_W-1:0]  nxt_op;
  logic [REG_W-1:0] nxt_src1, nxt_src2, nxt_dest;
  logic             nxt_clear, nxt_modwait, nxt_err;
  logic             prev_one_k;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE, EIDLE: begin
        if (dr)      nxt_state = STORE;
        else if (lc) nxt_state = LC0;
      end
      STORE: nxt_state = dr ? ZERO : EIDLE;
      ZERO:  nxt_state = SORT1;
      SORT1: nxt_state = SORT2;
      SORT2: nxt_state = SORT3;
      SORT3: nxt_state = SORT4;
      SORT4: nxt_state = MUL1;
      MUL1:  nxt_state = ADD1;
      ADD1:  nxt_state = overflow ? EIDLE : MUL2;
      MUL2:  nxt_state = SUB1;
      SUB1:  nxt_state = overflow ? EIDLE : MUL3;
      MUL3:  nxt_state = ADD2;
      ADD2:  nxt_state = overflow ? EIDLE : MUL4;
      MUL4:  nxt_state = SUB2;
      SUB2:  nxt_state = overflow ? EIDLE : IDLE;
      LC0:   nxt_state = WAIT1;
      WAIT1: if (lc) nxt_state = LC1;
      LC1:   nxt_state = WAIT2;
      WAIT2: if (lc) nxt_state = LC2;
      LC2:   nxt_state = WAIT3;
      WAIT3: if (lc) nxt_state = LC3;
      LC3:   nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so registered outputs line up with it
  always_comb begin
    nxt_op      = OP_NOP;
    nxt_src1    = '0;
    nxt_src2    = '0;
    nxt_dest    = '0;
    nxt_clear   = 1'b0;
    nxt_modwait = 1'b1;
    nxt_err     = 1'b0;
    case (nxt_state)
      IDLE, WAIT1, WAIT2, WAIT3: nxt_modwait = 1'b0;
      EIDLE: begin
        nxt_modwait = 1'b0;
        nxt_err     = 1'b1;
      end
      STORE: begin
        nxt_op   = OP_LOAD1;
        nxt_dest = REG_W'(5);
      end
      ZERO: nxt_op = OP_SUB;
      SORT1: begin
        nxt_op   = OP_COPY;
        nxt_src1 = REG_W'(2);
        nxt_dest = REG_W'(1);
      end
      SORT2: begin
        nxt_op   = OP_COPY;
        nxt_src1 = REG_W'(3);
        nxt_dest = REG_W'(2);
      end
      SORT3: begin
        nxt_op   = OP_COPY;
        nxt_src1 = REG_W'(4);
        nxt_dest = REG_W'(3);
      end
      SORT4: begin
        nxt_op   = OP_COPY;
        nxt_src1 = REG_W'(5);
        nxt_dest = REG_W'(4);
      end
      MUL1: begin
        nxt_op   = OP_MUL;
        nxt_src1 = REG_W'(1);
        nxt_src2 = REG_W'(6);
        nxt_dest = REG_W'(10);
      end
      MUL2: begin
        nxt_op   = OP_MUL;
        nxt_src1 = REG_W'(2);
        nxt_src2 = REG_W'(7);
        nxt_dest = REG_W'(10);
      end
      MUL3: begin
        nxt_op   = OP_MUL;
        nxt_src1 = REG_W'(3);
        nxt_src2 = REG_W'(8);
        nxt_dest = REG_W'(10);
      end
      MUL4: begin
        nxt_op   = OP_MUL;
        nxt_src1 = REG_W'(4);
        nxt_src2 = REG_W'(9);
        nxt_dest = REG_W'(10);
      end
      ADD1, ADD2: begin
        nxt_op   = OP_ADD;
        nxt_src2 = REG_W'(10);
      end
      SUB1, SUB2: begin
        nxt_op   = OP_SUB;
        nxt_src2 = REG_W'(10);
      end
      LC0: begin
        nxt_op    = OP_LOAD2;
        nxt_dest  = REG_W'(6);
        nxt_clear = 1'b1;
      end
      LC1: begin
        nxt_op   = OP_LOAD2;
        nxt_dest = REG_W'(7);
      end
      LC2: begin
        nxt_op   = OP_LOAD2;
        nxt_dest = REG_W'(8);
      end
      LC3: begin
        nxt_op   = OP_LOAD2;
        nxt_dest = REG_W'(9);
      end
      default: nxt_modwait = 1'b0;
    endcase
  end

  // Registered outputs and batch edge detect
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op         <= OP_NOP;
      src1       <= '0;
      src2       <= '0;
      dest       <= '0;
      clear      <= 1'b0;
      modwait    <= 1'b0;
      err        <= 1'b0;
      prev_one_k <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      op         <= nxt_op;
      src1       <= nxt_src1;
      src2       <= nxt_src2;
      dest       <= nxt_dest;
      clear      <= nxt_clear;
      modwait    <= nxt_modwait;
      err        <= nxt_err;
      prev_one_k <= one_k_samples;
      batch_done <= one_k_samples & ~prev_one_k;
    end
  end

  // Count only samples that finish the last accumulate without overflow
  assign cnt_up = (state == SUB2) && !overflow;

endmodule
